// File: rtl/move_pkg.sv
// rtl/move_pkg.sv - shared types, constants and SRAM address helper for move commit
package move_pkg;

   localparam int DEF_DEPTH   = 19;
   localparam int DEF_X_WIDTH = 10;
   localparam int DEF_Y_WIDTH = DEF_X_WIDTH;
   localparam int DEF_ADDR_W  = DEF_DEPTH + 3;

   localparam logic [3:0] TILE_EMPTY = 4'b0000;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CHK  = 3'd2,
      EVAL = 3'd3,
      WR   = 3'd4,
      UPD  = 3'd5,
      DONE = 3'd6
   } state_t;

   // Board cell address: y in the upper bits, x in the lower bits.
   function automatic logic [DEF_ADDR_W-1:0] sram_addr_of(
      input logic [DEF_Y_WIDTH:0] y,
      input logic [DEF_X_WIDTH:0] x
   );
      return {y, x};
   endfunction

endpackage

// File: rtl/bbox_tracker.sv
// rtl/bbox_tracker.sv - board bounding box; first enabled update seeds min and max
module bbox_tracker
   import move_pkg::*;
#(
   parameter int X_WIDTH = DEF_X_WIDTH,
   parameter int Y_WIDTH = DEF_Y_WIDTH
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_first,
   input  logic [X_WIDTH:0] i_x,
   input  logic [Y_WIDTH:0] i_y,
   output logic [X_WIDTH:0] o_min_x,
   output logic [X_WIDTH:0] o_max_x,
   output logic [Y_WIDTH:0] o_min_y,
   output logic [Y_WIDTH:0] o_max_y
);

   logic [X_WIDTH:0] r_min_x, r_max_x;
   logic [Y_WIDTH:0] r_min_y, r_max_y;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_min_x <= '0;
         r_max_x <= '0;
         r_min_y <= '0;
         r_max_y <= '0;
      end else if (i_en) begin
         if (i_first) begin
            r_min_x <= i_x;
            r_max_x <= i_x;
            r_min_y <= i_y;
            r_max_y <= i_y;
         end else begin
            if (i_x < r_min_x) r_min_x <= i_x;
            if (i_x > r_max_x) r_max_x <= i_x;
            if (i_y < r_min_y) r_min_y <= i_y;
            if (i_y > r_max_y) r_max_y <= i_y;
         end
      end
   end

   assign o_min_x = r_min_x;
   assign o_max_x = r_max_x;
   assign o_min_y = r_min_y;
   assign o_max_y = r_max_y;

endmodule

// File: rtl/move_commit.sv
// rtl/move_commit.sv - checks target cell and tile, writes the board SRAM, tracks stats
module move_commit
   import move_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int X_WIDTH = DEF_X_WIDTH,
   parameter int Y_WIDTH = DEF_Y_WIDTH
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic [X_WIDTH:0] i_x,
   input  logic [Y_WIDTH:0] i_y,
   input  logic [3:0]       i_tile,
   input  logic [3:0]       i_sram_data,
   output logic [DEPTH+2:0] o_sram_addr,
   output logic [3:0]       o_sram_data,
   output logic             o_sram_we,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_error,
   output logic [X_WIDTH:0] o_last_x,
   output logic [Y_WIDTH:0] o_last_y,
   output logic [X_WIDTH:0] o_min_x,
   output logic [X_WIDTH:0] o_max_x,
   output logic [Y_WIDTH:0] o_min_y,
   output logic [Y_WIDTH:0] o_max_y,
   output logic [15:0]      o_move_count
);

   state_t           r_state, w_next;
   logic [X_WIDTH:0] r_cx, r_last_x;
   logic [Y_WIDTH:0] r_cy, r_last_y;
   logic [3:0]       r_ctile, r_occ;
   logic             r_error;
   logic [15:0]      r_count;
   logic             w_reject, w_upd, w_first;

   assign w_reject = (r_occ != TILE_EMPTY) || (r_ctile == TILE_EMPTY);
   assign w_upd    = (r_state == UPD);
   assign w_first  = (r_count == 16'd0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_valid) w_next = RD;
         RD:      w_next = CHK;
         CHK:     w_next = EVAL;
         EVAL:    w_next = w_reject ? DONE : WR;
         WR:      w_next = UPD;
         UPD:     w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cx     <= '0;
         r_cy     <= '0;
         r_ctile  <= '0;
         r_occ    <= '0;
         r_error  <= 1'b0;
         r_count  <= '0;
         r_last_x <= '0;
         r_last_y <= '0;
      end else begin
         case (r_state)
            IDLE: if (i_valid) begin
               r_cx    <= i_x;
               r_cy    <= i_y;
               r_ctile <= i_tile;
               r_error <= 1'b0;
            end
            CHK:  r_occ <= i_sram_data;
            EVAL: if (w_reject) r_error <= 1'b1;
            UPD: begin
               r_last_x <= r_cx;
               r_last_y <= r_cy;
               if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
            end
            default: ;
         endcase
      end
   end

   bbox_tracker #(.X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH)) u_bbox (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (w_upd),
      .i_first (w_first),
      .i_x     (r_cx),
      .i_y     (r_cy),
      .o_min_x (o_min_x),
      .o_max_x (o_max_x),
      .o_min_y (o_min_y),
      .o_max_y (o_max_y)
   );

   // SRAM pins depend only on state and captured registers, never on i_*.
   assign o_sram_addr  = sram_addr_of(r_cy, r_cx);
   assign o_sram_we    = (r_state == WR);
   assign o_sram_data  = o_sram_we ? r_ctile : TILE_EMPTY;
   assign o_busy       = (r_state != IDLE);
   assign o_done       = (r_state == DONE);
   assign o_error      = r_error;
   assign o_last_x     = r_last_x;
   assign o_last_y     = r_last_y;
   assign o_move_count = r_count;

endmodule

// File: tb/tb_move_commit.sv
// tb/tb_move_commit.sv - self-checking bench for move_commit with board reference model
module tb_move_commit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [10:0] x, y;
   logic [3:0]  tile;
   logic [3:0]  sram_rdata;
   logic [21:0] addr;
   logic [3:0]  wdata;
   logic        we, busy, done, error;
   logic [10:0] last_x, last_y, min_x, max_x, min_y, max_y;
   logic [15:0] count;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   move_commit dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_valid      (valid),
      .i_x          (x),
      .i_y          (y),
      .i_tile       (tile),
      .i_sram_data  (sram_rdata),
      .o_sram_addr  (addr),
      .o_sram_data  (wdata),
      .o_sram_we    (we),
      .o_busy       (busy),
      .o_done       (done),
      .o_error      (error),
      .o_last_x     (last_x),
      .o_last_y     (last_y),
      .o_min_x      (min_x),
      .o_max_x      (max_x),
      .o_min_y      (min_y),
      .o_max_y      (max_y),
      .o_move_count (count)
   );

   // Board SRAM: synchronous read, data valid the cycle after the address.
   logic [3:0]  mem [logic [21:0]];
   logic        poke_en;
   logic [21:0] poke_addr;
   logic [3:0]  poke_data;

   always @(posedge clk) begin
      sram_rdata <= mem.exists(addr) ? mem[addr] : 4'h0;
      if (we)      mem[addr] = wdata;
      if (poke_en) mem[poke_addr] = poke_data;
   end

   // Reference model: board contents and commit statistics.
   logic [3:0]  m_board [logic [21:0]];
   int          m_count;
   logic [10:0] m_lx, m_ly, m_minx, m_maxx, m_miny, m_maxy;
   logic        m_err;

   task automatic model_reset();
      m_count = 0;
      m_lx = 0; m_ly = 0;
      m_minx = 0; m_maxx = 0; m_miny = 0; m_maxy = 0;
      m_err = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".error"}, 32'(error), 32'(m_err));
      chk({tag, ".count"}, 32'(count), 32'(m_count));
      chk({tag, ".last"},  32'({last_y, last_x}), 32'({m_ly, m_lx}));
      chk({tag, ".min"},   32'({min_y, min_x}),   32'({m_miny, m_minx}));
      chk({tag, ".max"},   32'({max_y, max_x}),   32'({m_maxy, m_maxx}));
      chk({tag, ".busy"},  32'(busy), 32'(0));
   endtask

   task automatic poke(input logic [10:0] px, input logic [10:0] py, input logic [3:0] pd);
      @(negedge clk);
      poke_en = 1'b1; poke_addr = {py, px}; poke_data = pd;
      @(posedge clk);
      #1 poke_en = 1'b0;
      m_board[{py, px}] = pd;
   endtask

   task automatic run_move(input string tag, input logic [10:0] mx, input logic [10:0] my,
                           input logic [3:0] mt, input bit dup);
      logic [21:0] a;
      bit          legal;
      int          done_at, ndone, nwe, we_at;
      logic [21:0] we_addr;
      logic [3:0]  we_data;
      a = {my, mx};
      legal = !(m_board.exists(a) && m_board[a] != 4'h0) && (mt != 4'h0);
      done_at = 0; ndone = 0; nwe = 0; we_at = 0; we_addr = '0; we_data = '0;
      @(negedge clk);
      valid = 1'b1; x = mx; y = my; tile = mt;
      @(posedge clk);
      #1 valid = 1'b0; x = 11'($urandom); y = 11'($urandom); tile = 4'($urandom);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            chk({tag, ".busy1"}, 32'(busy), 32'(1));
            chk({tag, ".err_clr"}, 32'(error), 32'(0));
         end
         if (we) begin nwe++; we_at = k; we_addr = addr; we_data = wdata; end
         if (done) begin ndone++; done_at = k; end
         if (k == 2 && dup) begin
            valid = 1'b1; x = 11'($urandom); y = 11'($urandom); tile = 4'($urandom_range(1, 15));
         end
         if (k == 3) valid = 1'b0;
      end
      if (legal) begin
         m_board[a] = mt;
         if (m_count == 0) begin
            m_minx = mx; m_maxx = mx; m_miny = my; m_maxy = my;
         end else begin
            m_minx = (mx < m_minx) ? mx : m_minx;
            m_maxx = (mx > m_maxx) ? mx : m_maxx;
            m_miny = (my < m_miny) ? my : m_miny;
            m_maxy = (my > m_maxy) ? my : m_maxy;
         end
         if (m_count < 65535) m_count++;
         m_lx = mx; m_ly = my;
         m_err = 1'b0;
      end else begin
         m_err = 1'b1;
      end
      chk({tag, ".ndone"},   32'(ndone),   32'(1));
      chk({tag, ".done_at"}, 32'(done_at), legal ? 32'(6) : 32'(4));
      chk({tag, ".nwe"},     32'(nwe),     legal ? 32'(1) : 32'(0));
      if (legal) begin
         chk({tag, ".we_at"}, 32'(we_at),   32'(4));
         chk({tag, ".waddr"}, 32'(we_addr), 32'(a));
         chk({tag, ".wdata"}, 32'(we_data), 32'(mt));
      end
      chk_state(tag);
   endtask

   initial begin
      logic [10:0] rx, ry;
      logic [3:0]  rt;
      bit          rd;
      rst_n = 1'b0; valid = 1'b0; x = '0; y = '0; tile = '0;
      poke_en = 1'b0; poke_addr = '0; poke_data = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst.we",   32'(we),    32'(0));
      chk("rst.done", 32'(done),  32'(0));
      chk("rst.addr", 32'(addr),  32'(0));
      chk_state("rst");
      rst_n = 1'b1;

      run_move("m1", 11'd5, 11'd7, 4'd3, 1'b0);
      run_move("m2", 11'd4, 11'd9, 4'd2, 1'b0);
      poke(11'd3, 11'd2, 4'h6);
      run_move("occ", 11'd3, 11'd2, 4'd1, 1'b0);
      run_move("tile0", 11'd10, 11'd10, 4'd0, 1'b0);
      repeat (4) @(negedge clk);
      chk("err_hold", 32'(error), 32'(1));
      run_move("dup", 11'd6, 11'd1, 4'd5, 1'b1);
      run_move("self_occ", 11'd5, 11'd7, 4'd9, 1'b0);

      // Reset pulled low in the middle of the WR cycle.
      @(negedge clk);
      valid = 1'b1; x = 11'd1; y = 11'd1; tile = 4'd7;
      @(posedge clk);
      #1 valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("wr_rst.we_before", 32'(we), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("wr_rst.we_after", 32'(we),   32'(0));
      chk("wr_rst.addr",     32'(addr), 32'(0));
      chk_state("wr_rst");
      @(negedge clk);
      rst_n = 1'b1;
      run_move("after_rst", 11'd1, 11'd1, 4'd7, 1'b0);

      for (int i = 0; i < 40; i++) begin
         rx = 11'($urandom_range(0, 5));
         ry = 11'($urandom_range(0, 5));
         if ($urandom_range(0, 4) == 0) rx = 11'($urandom);
         if ($urandom_range(0, 4) == 0) ry = 11'($urandom);
         rt = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         rd = ($urandom_range(0, 3) == 0);
         run_move("rnd", rx, ry, rt, rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
